predecode_queue: RTL

- Multi-lane pre-decode stage plus instruction buffer, placed between fetch and decode/dispatch.
- Accepts up to FETCH_WIDTH instructions per cycle.
- Classifies each instruction as conditional branch, unconditional branch, JAL, JALR, call or return.
- Drops lanes after the first unconditional jump, issues an early registered redirect for JAL targets, and buffers results in a circular FIFO drained up to DISPATCH_WIDTH per cycle.

---
 rtl/predecode_queue_pkg.sv | 32 +++
 rtl/predecode_lane.sv | 43 ++++
 rtl/predecode_queue.sv | 132 +++++++++++++
 3 files changed

// File: rtl/predecode_queue_pkg.sv
// rtl/predecode_queue_pkg.sv - shared types, ISA constants and helpers for the predecode queue
package predecode_queue_pkg;

  localparam int INST_W = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  typedef struct packed {
    logic cond_branch;
    logic uncond_branch;
    logic jump;
    logic jump_back;
    logic is_call;
    logic is_return;
  } predecode_info_t;

  // x1 and x5 are the two registers the calling convention treats as link registers.
  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

  // Takes inst[31:12] and returns the sign-extended J-type offset (bit 0 always zero).
  function automatic logic [31:0] j_imm(input logic [19:0] upper);
    return {{12{upper[19]}}, upper[7:0], upper[8], upper[18:9], 1'b0};
  endfunction

endpackage

// File: rtl/predecode_lane.sv
// rtl/predecode_lane.sv - combinational control-flow classifier for one fetch lane
module predecode_lane
  import predecode_queue_pkg::*;
(
  input  logic                  valid,
  input  logic [INST_W-1:0]     inst,
  input  logic [31:0]           pc,
  output predecode_info_t       info,
  output logic [31:0]           j_target
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       is_cond;
  logic       is_jal;
  logic       is_jalr;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];

  // Decode the branch/jump class; funct3 010/011 are not defined branch encodings.
  always_comb begin
    info    = '0;
    is_cond = (opcode == OPC_BRANCH) && (funct3 != 3'b010) && (funct3 != 3'b011);
    is_jal  = (opcode == OPC_JAL);
    is_jalr = (opcode == OPC_JALR) && (funct3 == 3'b000);
    if (valid) begin
      info.cond_branch   = is_cond;
      info.uncond_branch = is_jal || is_jalr;
      info.jump          = is_jal;
      info.jump_back     = is_jalr;
      info.is_call       = (is_jal || is_jalr) && is_link_reg(rd);
      info.is_return     = is_jalr && is_link_reg(rs1) && !is_link_reg(rd);
    end
  end

  assign j_target = pc + j_imm(inst[31:12]);

endmodule

// File: rtl/predecode_queue.sv
// rtl/predecode_queue.sv - multi-lane predecode with early JAL redirect feeding a circular instruction buffer
module predecode_queue
  import predecode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH    = 2,
  parameter int DISPATCH_WIDTH = 2,
  parameter int DEPTH          = 8
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  input  logic                                     flush,
  input  logic [FETCH_WIDTH-1:0]                   if_valid,
  input  logic [FETCH_WIDTH-1:0][INST_W-1:0]       if_inst,
  input  logic [FETCH_WIDTH-1:0][31:0]             if_pc,
  output logic                                     if_ready,
  output logic                                     redirect_valid,
  output logic [31:0]                              redirect_pc,
  output logic [DISPATCH_WIDTH-1:0]                out_valid,
  output logic [DISPATCH_WIDTH-1:0][INST_W-1:0]    out_inst,
  output logic [DISPATCH_WIDTH-1:0][31:0]          out_pc,
  output predecode_info_t [DISPATCH_WIDTH-1:0]     out_info,
  input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]      dis_take,
  output logic [$clog2(DEPTH+1)-1:0]               count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENQ_W = $clog2(FETCH_WIDTH + 1);

  predecode_info_t [FETCH_WIDTH-1:0] lane_info;
  logic [FETCH_WIDTH-1:0][31:0]      lane_tgt;

  logic [FETCH_WIDTH-1:0] keep;
  logic [ENQ_W-1:0]       n_enq;
  logic                   stop;
  logic                   jal_hit;
  logic [31:0]            jal_target;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             space_ok;
  logic             enq_fire;
  logic [CNT_W-1:0] take_ext;
  logic [CNT_W-1:0] taken;

  logic [INST_W-1:0]  mem_inst [DEPTH];
  logic [31:0]        mem_pc   [DEPTH];
  predecode_info_t    mem_info [DEPTH];

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    predecode_lane u_lane (
      .valid    (if_valid[g]),
      .inst     (if_inst[g]),
      .pc       (if_pc[g]),
      .info     (lane_info[g]),
      .j_target (lane_tgt[g])
    );
  end

  // Keep the contiguous valid run from lane 0, ending at the first unconditional jump.
  always_comb begin
    keep       = '0;
    n_enq      = '0;
    stop       = 1'b0;
    jal_hit    = 1'b0;
    jal_target = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!stop && if_valid[i]) begin
        keep[i] = 1'b1;
        n_enq   = n_enq + ENQ_W'(1);
        if (lane_info[i].uncond_branch) begin
          stop       = 1'b1;
          jal_hit    = lane_info[i].jump;
          jal_target = lane_tgt[i];
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  // Space is judged on the pre-cycle count so a same-cycle dequeue never frees room for fetch.
  assign space_ok = count <= CNT_W'(DEPTH - FETCH_WIDTH);
  assign if_ready = !reset_n || space_ok;
  assign enq_fire = reset_n && !flush && space_ok;
  assign take_ext = CNT_W'(dis_take);
  assign taken    = (take_ext > count) ? count : take_ext;

  // Pointer, occupancy and redirect state; flush clears like reset.
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      head           <= head + PTR_W'(taken);
      if (enq_fire) tail <= tail + PTR_W'(n_enq);
      count          <= count + (enq_fire ? CNT_W'(n_enq) : CNT_W'(0)) - taken;
      redirect_valid <= enq_fire && jal_hit;
      if (enq_fire && jal_hit) redirect_pc <= jal_target;
    end
  end

  // Write kept lanes into consecutive slots starting at tail.
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (keep[i]) begin
          mem_inst[tail + PTR_W'(i)] <= if_inst[i];
          mem_pc[tail + PTR_W'(i)]   <= if_pc[i];
          mem_info[tail + PTR_W'(i)] <= lane_info[i];
        end
      end
    end
  end

  // Present the oldest entries to dispatch, head first.
  always_comb begin
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      out_valid[i] = reset_n && (CNT_W'(i) < count);
      out_inst[i]  = mem_inst[head + PTR_W'(i)];
      out_pc[i]    = mem_pc[head + PTR_W'(i)];
      out_info[i]  = mem_info[head + PTR_W'(i)];
    end
  end

  // Dispatch may never consume more entries than are buffered.
  a_take_le_count: assert property (@(posedge clock) disable iff (!reset_n || flush) take_ext <= count);

endmodule
